// File: rtl/seq_detect_pkg.sv
// Shared definitions for the serial pattern detector: FSM state encoding and
// the width of the history fill counter.
package seq_detect_pkg;

   typedef enum logic {
      ST_FILL  = 1'b0,
      ST_ARMED = 1'b1
   } state_t;

   // Fill counter must represent 0..pattern_w inclusive
   function automatic int fill_width(input int pattern_w);
      return $clog2(pattern_w + 1);
   endfunction

endpackage

// File: rtl/seq_detect_shift_reg.sv
// History register for seq_detect: shifts d in at the LSB on each enabled
// sample, so the MSB holds the oldest bit.
module seq_shift_reg #(
   parameter int PATTERN_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic                 d,
   output logic [PATTERN_W-1:0] q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= '0;
      end else if (en) begin
         q <= {q[PATTERN_W-2:0], d};
      end
   end

endmodule

// File: rtl/seq_detect.sv
// Serial bit-pattern detector: registered one-cycle match pulse, saturating
// match counter with sticky overflow, optional overlapping detection.
module seq_detect
   import seq_detect_pkg::*;
#(
   parameter int                   PATTERN_W = 4,
   parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
   parameter bit                   OVERLAP   = 1'b1,
   parameter int                   CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             d,
   input  logic             en,
   input  logic             clr,
   output logic             match,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cnt_ovf,
   output logic             armed
);

   localparam int                FILL_W    = fill_width(PATTERN_W);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);

   logic [PATTERN_W-1:0] shreg;
   logic [PATTERN_W-1:0] shreg_n;
   logic [FILL_W-1:0]    fill;
   logic [FILL_W-1:0]    fill_inc;
   logic [FILL_W-1:0]    fill_n;
   state_t               state;
   state_t               state_n;
   logic                 hit;

   seq_shift_reg #(
      .PATTERN_W(PATTERN_W)
   ) u_shreg (
      .clk(clk),
      .rst(rst),
      .en (en),
      .d  (d),
      .q  (shreg)
   );

   always_comb begin
      shreg_n  = {shreg[PATTERN_W-2:0], d};
      fill_inc = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
      fill_n   = fill;
      state_n  = state;
      hit      = 1'b0;
      if (en) begin
         hit     = (fill_inc == FILL_FULL) && (shreg_n == PATTERN);
         fill_n  = fill_inc;
         state_n = (fill_inc == FILL_FULL) ? ST_ARMED : ST_FILL;
         // Non-overlapping mode: the next match must be built from fresh bits
         if (hit && !OVERLAP) begin
            fill_n  = '0;
            state_n = ST_FILL;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_FILL;
         fill      <= '0;
         match     <= 1'b0;
         match_cnt <= '0;
         cnt_ovf   <= 1'b0;
      end else begin
         state <= state_n;
         fill  <= fill_n;
         match <= hit;
         // clr takes priority over a coincident hit; the pulse still fires
         if (clr) begin
            match_cnt <= '0;
            cnt_ovf   <= 1'b0;
         end else if (hit) begin
            if (match_cnt != '1) begin
               match_cnt <= match_cnt + CNT_W'(1);
            end else begin
               cnt_ovf <= 1'b1;
            end
         end
      end
   end

   assign armed = (state == ST_ARMED);

endmodule

// File: tb/tb_seq_detect.sv
// Bench for seq_detect: three instances (default, non-overlapping, 2-bit
// counter) share one stimulus stream and are compared to a sample-list model.
module tb_seq_detect;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic d   = 1'b0;
   logic en  = 1'b0;
   logic clr = 1'b0;

   logic       m_a, ov_a, ar_a;
   logic [7:0] cnt_a;
   logic       m_b, ov_b, ar_b;
   logic [7:0] cnt_b;
   logic       m_c, ov_c, ar_c;
   logic [1:0] cnt_c;

   int tests  = 0;
   int failed = 0;

   always #100 clk = ~clk;

   seq_detect dut_a (
      .clk(clk), .rst(rst), .d(d), .en(en), .clr(clr),
      .match(m_a), .match_cnt(cnt_a), .cnt_ovf(ov_a), .armed(ar_a)
   );

   seq_detect #(.OVERLAP(1'b0)) dut_b (
      .clk(clk), .rst(rst), .d(d), .en(en), .clr(clr),
      .match(m_b), .match_cnt(cnt_b), .cnt_ovf(ov_b), .armed(ar_b)
   );

   seq_detect #(.CNT_W(2)) dut_c (
      .clk(clk), .rst(rst), .d(d), .en(en), .clr(clr),
      .match(m_c), .match_cnt(cnt_c), .cnt_ovf(ov_c), .armed(ar_c)
   );

   // Reference model: every accepted sample is appended to seq; start[i] is
   // the index from which instance i may use samples (moved on reset, and on
   // a match when overlapping is off).
   bit   seq[$];
   int   start[3];
   bit   mexp[3];
   int   cexp[3];
   bit   oexp[3];
   int   cmax[3] = '{255, 255, 3};
   bit   ovl[3]  = '{1'b1, 1'b0, 1'b1};
   logic [3:0] pat = 4'b1011;

   function automatic bit tail_hit(input int s);
      int n;
      n = seq.size();
      if (n - s < 4) return 1'b0;
      for (int k = 0; k < 4; k++)
         if (seq[n - 4 + k] != pat[3 - k]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit armed_m(input int i);
      return (seq.size() - start[i]) >= 4;
   endfunction

   task automatic model_edge(input bit r, input bit e, input bit dd, input bit c);
      if (r) begin
         for (int i = 0; i < 3; i++) begin
            start[i] = seq.size();
            mexp[i]  = 1'b0;
            cexp[i]  = 0;
            oexp[i]  = 1'b0;
         end
      end else begin
         if (e) seq.push_back(dd);
         for (int i = 0; i < 3; i++) begin
            bit hit;
            hit = e && tail_hit(start[i]);
            if (hit && !ovl[i]) start[i] = seq.size();
            if (c) begin
               cexp[i] = 0;
               oexp[i] = 1'b0;
            end else if (hit) begin
               if (cexp[i] < cmax[i]) cexp[i]++;
               else oexp[i] = 1'b1;
            end
            mexp[i] = hit;
         end
      end
   endtask

   function automatic logic [26:0] obs_vec();
      return {m_a, ar_a, ov_a, cnt_a, m_b, ar_b, ov_b, cnt_b, m_c, ar_c, ov_c, cnt_c};
   endfunction

   function automatic logic [26:0] exp_vec();
      return {mexp[0], armed_m(0), oexp[0], 8'(cexp[0]),
              mexp[1], armed_m(1), oexp[1], 8'(cexp[1]),
              mexp[2], armed_m(2), oexp[2], 2'(cexp[2])};
   endfunction

   // One clock: inputs change mid-low phase, outputs sampled 1 after the edge
   task automatic do_edge(input bit r, input bit e, input bit dd, input bit c);
      @(negedge clk);
      #50;
      rst = r; en = e; d = dd; clr = c;
      @(posedge clk);
      model_edge(r, e, dd, c);
      #1;
   endtask

   task automatic test_reset();
      do_edge(1'b1, 1'b0, 1'b0, 1'b0);
      do_edge(1'b1, 1'b1, 1'b1, 1'b1);
      tests++;
      if (obs_vec() !== exp_vec()) begin
         failed++;
         $display("FAIL reset_model got=%h want=%h", obs_vec(), exp_vec());
      end
      tests++;
      if ({m_a, ar_a, ov_a, cnt_a} !== 11'd0) begin
         failed++;
         $display("FAIL reset_state got=%b want=0", {m_a, ar_a, ov_a, cnt_a});
      end
   endtask

   task automatic test_basic();
      bit bits[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      do_edge(1'b1, 1'b0, 1'b0, 1'b0);
      foreach (bits[i]) begin
         do_edge(1'b0, 1'b1, bits[i], 1'b0);
         tests++;
         if (obs_vec() !== exp_vec()) begin
            failed++;
            $display("FAIL basic_bit%0d got=%h want=%h", i, obs_vec(), exp_vec());
         end
      end
      tests++;
      if ({m_a, ar_a, cnt_a} !== {1'b1, 1'b1, 8'd1}) begin
         failed++;
         $display("FAIL basic_match got=%b/%b/%0d want=1/1/1", m_a, ar_a, cnt_a);
      end
      do_edge(1'b0, 1'b1, 1'b0, 1'b0);
      tests++;
      if (m_a !== 1'b0 || obs_vec() !== exp_vec()) begin
         failed++;
         $display("FAIL basic_pulse_end got=%h want=%h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_overlap();
      bit bits[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      do_edge(1'b1, 1'b0, 1'b0, 1'b0);
      foreach (bits[i]) begin
         do_edge(1'b0, 1'b1, bits[i], 1'b0);
         tests++;
         if (obs_vec() !== exp_vec()) begin
            failed++;
            $display("FAIL overlap_bit%0d got=%h want=%h", i, obs_vec(), exp_vec());
         end
      end
      tests++;
      if (cnt_a !== 8'd2 || cnt_b !== 8'd1 || ar_b !== 1'b0) begin
         failed++;
         $display("FAIL overlap_counts got=%0d/%0d/%b want=2/1/0", cnt_a, cnt_b, ar_b);
      end
   endtask

   task automatic test_reset_mid();
      bit bits[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      bit rsts[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      do_edge(1'b1, 1'b0, 1'b0, 1'b0);
      foreach (bits[i]) begin
         do_edge(rsts[i], 1'b1, bits[i], 1'b0);
         tests++;
         if (obs_vec() !== exp_vec()) begin
            failed++;
            $display("FAIL reset_mid_step%0d got=%h want=%h", i, obs_vec(), exp_vec());
         end
      end
      tests++;
      if ({m_a, ar_a, cnt_a} !== 10'd0) begin
         failed++;
         $display("FAIL reset_mid_nomatch got=%b/%b/%0d want=0/0/0", m_a, ar_a, cnt_a);
      end
   endtask

   task automatic test_saturate();
      bit bits[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      do_edge(1'b1, 1'b0, 1'b0, 1'b0);
      for (int n = 0; n < 5; n++) begin
         foreach (bits[i]) begin
            do_edge(1'b0, 1'b1, bits[i], 1'b0);
            tests++;
            if (obs_vec() !== exp_vec()) begin
               failed++;
               $display("FAIL saturate_m%0d_b%0d got=%h want=%h", n, i, obs_vec(), exp_vec());
            end
         end
      end
      tests++;
      if (cnt_c !== 2'd3 || ov_c !== 1'b1 || cnt_a !== 8'd5) begin
         failed++;
         $display("FAIL saturate_final got=%0d/%b/%0d want=3/1/5", cnt_c, ov_c, cnt_a);
      end
   endtask

   task automatic test_clr_hit();
      bit bits[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
      foreach (bits[i]) begin
         do_edge(1'b0, 1'b1, bits[i], (i == 3));
         tests++;
         if (obs_vec() !== exp_vec()) begin
            failed++;
            $display("FAIL clr_hit_bit%0d got=%h want=%h", i, obs_vec(), exp_vec());
         end
      end
      tests++;
      if ({m_c, ov_c, cnt_c} !== {1'b1, 1'b0, 2'd0}) begin
         failed++;
         $display("FAIL clr_hit_final got=%b/%b/%0d want=1/0/0", m_c, ov_c, cnt_c);
      end
   endtask

   task automatic test_en_hold();
      do_edge(1'b1, 1'b0, 1'b0, 1'b0);
      do_edge(1'b0, 1'b1, 1'b1, 1'b0);
      do_edge(1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         do_edge(1'b0, 1'b0, i[0], 1'b0);
         tests++;
         if (obs_vec() !== exp_vec() || m_a !== 1'b0) begin
            failed++;
            $display("FAIL en_hold_idle%0d got=%h want=%h", i, obs_vec(), exp_vec());
         end
      end
      do_edge(1'b0, 1'b1, 1'b1, 1'b0);
      do_edge(1'b0, 1'b1, 1'b1, 1'b0);
      tests++;
      if (m_a !== 1'b1 || cnt_a !== 8'd1 || obs_vec() !== exp_vec()) begin
         failed++;
         $display("FAIL en_hold_match got=%h want=%h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_random();
      do_edge(1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 400; i++) begin
         bit r, e, dd, c;
         r  = ($urandom_range(0, 99) < 2);
         e  = ($urandom_range(0, 99) < 75);
         dd = 1'($urandom);
         c  = ($urandom_range(0, 99) < 4);
         do_edge(r, e, dd, c);
         tests++;
         if (obs_vec() !== exp_vec()) begin
            failed++;
            $display("FAIL random_cyc%0d got=%h want=%h", i, obs_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         start[i] = 0;
         mexp[i]  = 1'b0;
         cexp[i]  = 0;
         oexp[i]  = 1'b0;
      end
      test_reset();
      test_basic();
      test_overlap();
      test_reset_mid();
      test_saturate();
      test_clr_hit();
      test_en_hold();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
